riscv_single_cycle_core: RTL and testbench
==========================================

# riscv_single_cycle_core

Single-cycle RV32I integer core: fetches one 32-bit instruction per clock from an external combinational-read instruction ROM, executes it, and accesses an external word-wide data RAM (synchronous write, combinational read). It owns the PC, the 32×32 register file, the decoder, the immediate generator, the ALU and the branch logic. The ROM, the RAM and the clock/reset generation sit outside this block, in the enclosing system or testbench.

## Interface
- ADDR_WIDTH, 10: word-address width of both the ROM and the RAM ports.
- SIZE, 32: data and instruction width. Only 32 is supported.

- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- Q_ROM  in  SIZE  instruction word at ADDR_ROM (combinational).
- ADDR_ROM  out  ADDR_WIDTH  instruction word address = PC[ADDR_WIDTH+1:2].
- ADDR_RAM  out  ADDR_WIDTH  data word address = ALU result[ADDR_WIDTH+1:2]; serves both read and write.
- Q_RAM  in  SIZE  RAM read data at ADDR_RAM (combinational).
- Q_W  out  SIZE  store data = rs2 value.
- ENABLE_W  out  1  RAM write enable; high only for a decoded SW while RESET_N=1.

## Operation
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Any other opcode/funct combination executes as a NOP:
  - PC advances by 4.
  - No register write; ENABLE_W=0.
- Immediates use the standard I/S/B/U/J encodings, sign-extended to 32 bits.
- ALU arithmetic:
  - All arithmetic is mod 2^32; no overflow traps.
  - Shift amount = low 5 bits of the operand.
  - SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
- Register file:
  - 32×32; x0 reads 0 and ignores writes.
  - Two combinational read ports, one write port.
  - Write occurs on the rising edge when the instruction writes rd.
- Write-back source:
  - ALU result for ALU ops and AUIPC.
  - Immediate for LUI.
  - Q_RAM for LW.
  - PC+4 for JAL/JALR.
- Next PC:
  - Taken branch or JAL: PC + imm.
  - JALR: (rs1 + imm) & ~1.
  - Otherwise: PC+4.
  - PC wraps mod 2^32.
- Memory access:
  - Word-only. PC bits [1:0] and address bits [1:0] are ignored.
  - Address bits above ADDR_WIDTH+1 are ignored, so accesses alias.
- SW: ENABLE_W=1, ADDR_RAM=rs1+imm, Q_W=rs2, all within the same cycle. The RAM captures the data on the next rising edge.

## Timing
- Reset (RESET_N=0), taking effect immediately and asynchronously:
  - PC=0; all registers = 0.
  - ENABLE_W forced 0; ADDR_ROM=0.
- ADDR_RAM and Q_W during reset are don't-care.
- First instruction: the word at ROM address 0 executes in the first rising edge after RESET_N rises.
- Throughput and latency:
  - CPI = 1.
  - Architectural effects (rd write, PC update, RAM write) commit together on that instruction's rising edge.
  - All outputs are combinational from PC and the current instruction within the cycle.
- Same-cycle hazards:
  - An instruction reading a register written by the previous instruction sees the new value; there are no hazards.
  - LW reads RAM combinationally in the same cycle as its address is presented.
- Reset asserted mid-program aborts the current instruction: no register or RAM write commits.

## Test plan
- Reset: hold RESET_N=0 two cycles -> ADDR_ROM=0, ENABLE_W=0; release -> ADDR_ROM increments 0,1,2,... each cycle with NOP-only ROM.
- ALU: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2; SLT x5,x2,x1; SLTU x6,x2,x1 -> x3=2, x4=8, x5=1, x6=0; SRAI of 0x80000000 by 4 -> 0xF8000000.
- Memory: ADDI x1,x0,0x40; ADDI x2,x0,0x7B; SW x2,4(x1) -> that cycle ENABLE_W=1, ADDR_RAM=17, Q_W=0x7B; then LW x3,4(x1) -> x3=0x7B.
- Branches: BEQ taken with offset +8 skips one instruction (ADDR_ROM jumps by 2); BNE not taken -> +1; BLTU with 0xFFFFFFFF vs 1 is not taken, while BLT on the same operands is taken.
- Jumps: JAL x1,+12 at PC 8 -> x1=12, ADDR_ROM=5; JALR x0,1(x1) with x1=12 -> PC=12 (bit 0 cleared); LUI x5,0x12345 -> 0x12345000; AUIPC at PC 16 with imm 1 -> 0x1010.
- x0/illegal: ADDI x0,x0,7 then ADD x1,x0,x0 -> x1=0; opcode 0x00000000 -> PC+4, no write, ENABLE_W=0.

Source files
------------

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I core: one instruction is fetched, executed and committed per clock.
// Instruction ROM and data RAM are external; RAM writes are captured by the RAM on the next edge.
module riscv_single_cycle_core #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SIZE       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [SIZE-1:0]       Q_ROM,
  output logic [ADDR_WIDTH-1:0] ADDR_ROM,
  output logic [ADDR_WIDTH-1:0] ADDR_RAM,
  input  logic [SIZE-1:0]       Q_RAM,
  output logic [SIZE-1:0]       Q_W,
  output logic                  ENABLE_W
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbImm  = 2'd1;
  localparam logic [1:0] WbMem  = 2'd2;
  localparam logic [1:0] WbLink = 2'd3;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] rf_q [32];

  logic [31:0] ins;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;

  logic        rd_we, is_store, is_branch, is_jal, is_jalr, alu_a_pc, alu_b_imm;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res, wb_data;
  logic [4:0]  shamt;
  logic        br_cond, br_taken;

  assign ins    = Q_ROM;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign rd     = ins[11:7];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];

  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Illegal encodings leave every side-effect strobe low, so they fall through as PC+4 NOPs.
  always_comb begin
    rd_we     = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b1;
    wb_sel    = WbAlu;
    alu_op    = 4'b0000;
    imm       = imm_i;
    case (opcode)
      OpLui: begin
        rd_we  = 1'b1;
        wb_sel = WbImm;
        imm    = imm_u;
      end
      OpAuipc: begin
        rd_we    = 1'b1;
        alu_a_pc = 1'b1;
        imm      = imm_u;
      end
      OpJal: begin
        rd_we  = 1'b1;
        is_jal = 1'b1;
        wb_sel = WbLink;
        imm    = imm_j;
      end
      OpJalr: begin
        rd_we   = (funct3 == 3'b000);
        is_jalr = (funct3 == 3'b000);
        wb_sel  = WbLink;
      end
      OpBranch: begin
        is_branch = (funct3[2:1] != 2'b01);
        imm       = imm_b;
      end
      OpLoad: begin
        rd_we  = (funct3 == 3'b010);
        wb_sel = WbMem;
      end
      OpStore: begin
        is_store = (funct3 == 3'b010);
        imm      = imm_s;
      end
      OpImm: begin
        if (funct3 == 3'b001)      rd_we = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) rd_we = ((funct7 & 7'b1011111) == 7'b0000000);
        else                       rd_we = 1'b1;
        alu_op = {(funct3 == 3'b101) && funct7[5], funct3};
      end
      OpReg: begin
        rd_we     = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
        alu_b_imm = 1'b0;
        alu_op    = {funct7[5], funct3};
      end
      default: ;
    endcase
  end

  assign alu_a = alu_a_pc ? pc_q : rs1_val;
  assign alu_b = alu_b_imm ? imm : rs2_val;
  assign shamt = alu_b[4:0];

  // alu_op = {alternate-op bit, funct3}
  always_comb begin
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a << shamt;
      4'b0010: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_res = {31'b0, alu_a < alu_b};
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a >> shamt;
      4'b1101: alu_res = $unsigned($signed(alu_a) >>> shamt);
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      default: alu_res = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_cond = (rs1_val < rs2_val);
      3'b111:  br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = is_branch && br_cond;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (is_jalr)                 pc_d = {alu_res[31:1], 1'b0};
    else if (is_jal || br_taken) pc_d = pc_q + imm;
    else                         pc_d = pc_plus4;
  end

  always_comb begin
    case (wb_sel)
      WbImm:   wb_data = imm;
      WbMem:   wb_data = Q_RAM;
      WbLink:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rd_we && (rd != 5'd0)) begin
      rf_q[rd] <= wb_data;
    end
  end

  assign ADDR_ROM = pc_q[ADDR_WIDTH+1:2];
  assign ADDR_RAM = alu_res[ADDR_WIDTH+1:2];
  assign Q_W      = rs2_val;
  assign ENABLE_W = is_store && RESET_N;

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Bench for riscv_single_cycle_core: ROM/RAM models, an instruction-level reference model
// that queues per-cycle expected outputs, and a monitor that checks them on the falling edge.
module tb_riscv_single_cycle_core;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] Q_ROM, Q_RAM, Q_W;
  logic [9:0]  ADDR_ROM, ADDR_RAM;
  logic        ENABLE_W;

  riscv_single_cycle_core #(.ADDR_WIDTH(10), .SIZE(32)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .Q_ROM    (Q_ROM),
    .ADDR_ROM (ADDR_ROM),
    .ADDR_RAM (ADDR_RAM),
    .Q_RAM    (Q_RAM),
    .Q_W      (Q_W),
    .ENABLE_W (ENABLE_W)
  );

  always #5 CLK = ~CLK;

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];
  logic        ram_clr = 1'b0;

  assign Q_ROM = rom[ADDR_ROM];
  assign Q_RAM = ram[ADDR_RAM];

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else if (ENABLE_W) begin
      ram[ADDR_RAM] <= Q_W;
    end
  end

  typedef struct {
    int          prog;
    int          cyc;
    logic [9:0]  addr_rom;
    logic        en_w;
    logic        chk_addr;
    logic        chk_qw;
    logic [9:0]  addr_ram;
    logic [31:0] q_w;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          nfail = 0;
  int          prog_id = 0;
  logic [31:0] prog[$];

  // Reference architectural state
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic [31:0] m_ram [1024];

  task automatic check(input string what, input exp_t e, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s prog %0d cycle %0d: got %h, required %h", what, e.prog, e.cyc, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("addr_rom", e, {22'b0, ADDR_ROM}, {22'b0, e.addr_rom});
        check("enable_w", e, {31'b0, ENABLE_W}, {31'b0, e.en_w});
        if (e.chk_addr) check("addr_ram", e, {22'b0, ADDR_RAM}, {22'b0, e.addr_ram});
        if (e.chk_qw) check("q_w", e, Q_W, e.q_w);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Encoders
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [31:0] imm,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(3'b000, rd, rs1, imm, 7'b0010011);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [31:0] imm);
    return enc_i(3'b010, rd, rs1, imm, 7'b0000011);
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r, f;
    logic [6:0]  f7;
    r  = $urandom;
    f  = $urandom;
    f7 = r[0] ? 7'h20 : (r[1] ? 7'h00 : r[31:25]);
    case ($urandom_range(0, 15))
      0:          return {r[31:12], f[11:7], 7'b0110111};
      1:          return {r[31:12], f[11:7], 7'b0010111};
      2:          return {r[31:12], f[11:7], 7'b1101111};
      3:          return {r[31:20], f[19:15], 3'b000, f[11:7], 7'b1100111};
      4, 5:       return {r[31:25], f[24:20], f[19:15], f[14:12], r[11:7], 7'b1100011};
      6:          return {r[31:20], f[19:15], 3'b010, f[11:7], 7'b0000011};
      7, 8:       return {r[31:25], f[24:20], f[19:15], 3'b010, r[11:7], 7'b0100011};
      9, 10, 11:  return {f7, r[24:20], f[19:15], f[14:12], f[11:7], 7'b0010011};
      12, 13, 14: return {f7, f[24:20], f[19:15], f[14:12], f[11:7], 7'b0110011};
      default:    return r;
    endcase
  endfunction

  // Integer operation per RV32I rules; ok=0 marks an encoding that is not an RV32I instruction.
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic is_imm, output logic ok);
    logic alt;
    alt = (f7 == 7'h20);
    if (is_imm) ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || alt) : 1'b1;
    else        ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
    case (f3)
      3'd0:    return (!is_imm && alt) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset(input bit clr_ram);
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    if (clr_ram) for (int i = 0; i < 1024; i++) m_ram[i] = '0;
  endtask

  task automatic push_reset(input int cyc);
    exp_t e;
    e = '{prog: prog_id, cyc: cyc, addr_rom: 10'd0, en_w: 1'b0, chk_addr: 1'b0, chk_qw: 1'b0,
          addr_ram: 10'd0, q_w: 32'd0};
    exp_q.push_back(e);
  endtask

  task automatic model_step(input int cyc);
    exp_t        e;
    logic [31:0] ins, a, b, res, nxt, addr, im_i, im_s, im_b, im_u, im_j;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        wr, ok, tk;
    ins  = rom[m_pc[11:2]];
    op   = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    a    = m_x[ins[19:15]];
    b    = m_x[ins[24:20]];
    im_i = {{20{ins[31]}}, ins[31:20]};
    im_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    im_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    im_u = {ins[31:12], 12'b0};
    im_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '{prog: prog_id, cyc: cyc, addr_rom: m_pc[11:2], en_w: 1'b0, chk_addr: 1'b0,
          chk_qw: 1'b0, addr_ram: 10'd0, q_w: 32'd0};
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    res = '0;
    case (op)
      7'b0110111: begin res = im_u; wr = 1'b1; end
      7'b0010111: begin res = m_pc + im_u; wr = 1'b1; end
      7'b1101111: begin res = m_pc + 32'd4; wr = 1'b1; nxt = m_pc + im_j; end
      7'b1100111: if (f3 == 3'd0) begin
        res = m_pc + 32'd4;
        wr  = 1'b1;
        nxt = (a + im_i) & ~32'd1;
      end
      7'b1100011: begin
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = ($signed(a) < $signed(b));
          3'd5:    tk = ($signed(a) >= $signed(b));
          3'd6:    tk = (a < b);
          3'd7:    tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + im_b;
      end
      7'b0000011: if (f3 == 3'd2) begin
        addr       = a + im_i;
        res        = m_ram[addr[11:2]];
        wr         = 1'b1;
        e.chk_addr = 1'b1;
        e.addr_ram = addr[11:2];
      end
      7'b0100011: if (f3 == 3'd2) begin
        addr              = a + im_s;
        e.en_w            = 1'b1;
        e.chk_addr        = 1'b1;
        e.chk_qw          = 1'b1;
        e.addr_ram        = addr[11:2];
        e.q_w             = b;
        m_ram[addr[11:2]] = b;
      end
      7'b0010011: begin res = alu_ref(f3, f7, a, im_i, 1'b1, ok); wr = ok; end
      7'b0110011: begin res = alu_ref(f3, f7, a, b, 1'b0, ok); wr = ok; end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = res;
    m_pc = nxt;
    exp_q.push_back(e);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 1024; i++) rom[i] = rand_ins();
  endtask

  // Two reset cycles, then `cycles` instructions; a reset is injected at cycle abort_at.
  task automatic run(input int cycles, input int abort_at);
    prog_id++;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    ram_clr = 1'b1;
    model_reset(1'b1);
    push_reset(-2);
    @(posedge CLK); #1;
    ram_clr = 1'b0;
    push_reset(-1);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (c == abort_at) begin
        RESET_N = 1'b0;
        model_reset(1'b0);
        push_reset(c);
        @(posedge CLK); #1;
        push_reset(c);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
      end
      model_step(c);
      @(posedge CLK); #1;
    end
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      @(negedge CLK); #1;
    end
    if (exp_q.size() != 0) begin
      tests++;
      nfail++;
      $display("FAIL drain prog %0d: %0d expectations never checked", prog_id, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset with a store at address 0 (write must stay gated), then NOPs
    prog = {sw(5'd0, 5'd0, 32'd0)};
    load_prog();
    run(6, -1);

    // ALU
    prog = {addi(5'd1, 5'd0, 32'd5), addi(5'd2, 5'd0, -32'sd3),
            enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),
            enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6),
            {20'h80000, 5'd7, 7'b0110111}, enc_i(3'd5, 5'd8, 5'd7, 32'h404, 7'b0010011),
            sw(5'd3, 5'd0, 32'd0), sw(5'd4, 5'd0, 32'd4), sw(5'd5, 5'd0, 32'd8),
            sw(5'd6, 5'd0, 32'd12), sw(5'd8, 5'd0, 32'd16)};
    load_prog();
    run(14, -1);

    // Memory
    prog = {addi(5'd1, 5'd0, 32'h40), addi(5'd2, 5'd0, 32'h7B), sw(5'd2, 5'd1, 32'd4),
            lw(5'd3, 5'd1, 32'd4), sw(5'd3, 5'd0, 32'd0)};
    load_prog();
    run(7, -1);

    // Branches
    prog = {addi(5'd1, 5'd0, -32'sd1), addi(5'd2, 5'd0, 32'd1),
            enc_b(3'd0, 5'd0, 5'd0, 32'd8), addi(5'd9, 5'd0, 32'd9),
            enc_b(3'd1, 5'd0, 5'd0, 32'd8), enc_b(3'd6, 5'd1, 5'd2, 32'd8),
            enc_b(3'd4, 5'd1, 5'd2, 32'd8), addi(5'd10, 5'd0, 32'd10),
            sw(5'd9, 5'd0, 32'd0), sw(5'd10, 5'd0, 32'd4)};
    load_prog();
    run(10, -1);

    // Jumps, LUI, AUIPC
    prog = {32'h0, 32'h0, jal(5'd1, 32'd12), {20'h12345, 5'd5, 7'b0110111},
            {20'h00001, 5'd6, 7'b0010111}, sw(5'd1, 5'd0, 32'd0), sw(5'd5, 5'd0, 32'd4),
            sw(5'd6, 5'd0, 32'd8), enc_i(3'd0, 5'd0, 5'd1, 32'd1, 7'b1100111)};
    load_prog();
    run(16, -1);

    // x0 and illegal encodings
    prog = {addi(5'd0, 5'd0, 32'd7), enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1),
            sw(5'd1, 5'd0, 32'd0), sw(5'd0, 5'd0, 32'd4), 32'h0,
            enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd7), sw(5'd7, 5'd0, 32'd8)};
    load_prog();
    run(8, -1);

    // Reset during a store: the store and prior register state must be discarded
    prog = {sw(5'd2, 5'd0, 32'd0), lw(5'd5, 5'd0, 32'd68), sw(5'd5, 5'd0, 32'd8),
            addi(5'd1, 5'd0, 32'h40), addi(5'd2, 5'd0, 32'h7B), sw(5'd2, 5'd1, 32'd4)};
    load_prog();
    run(12, 5);

    // Random programs over the whole ROM
    for (int p = 0; p < 4; p++) begin
      load_random();
      run(400, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, nfail);
    $finish;
  end

endmodule
